// File: rtl/rng_word_packer_if.sv
// Output word stream of the TRNG packer.
// Master drives data/valid, slave answers with ready.
interface rng_word_packer_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/rng_word_packer.sv
// Packs qualified TRNG bits LSB-first into words and buffers them in a FIFO.
// Overflow is flagged (sticky) instead of back-pressuring the generator.
module rng_word_packer #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       run_en,
    input  logic                       bit_valid,
    input  logic                       bit_in,
    rng_word_packer_if.master          out,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       overflow
);
    localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic              ovf_q, ovf_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];

    logic [WORD_W-1:0] word;
    logic              accept;
    logic              done;
    logic              full;
    logic              pop;
    logic              push;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        fill_d  = fill_q;
        ovf_d   = ovf_q;
        mem_d   = mem_q;

        word         = shift_q;
        word[cnt_q]  = bit_in;
        accept = (state_q == COLLECT) && run_en && bit_valid;
        done   = accept && (cnt_q == CW'(WORD_W - 1));
        full   = (fill_q == FW'(DEPTH));
        pop    = (fill_q != '0) && out.ready;
        // A pop in the same cycle frees the slot the push needs.
        push   = done && (!full || pop);

        if (clear) begin
            state_d = run_en ? COLLECT : IDLE;
            cnt_d   = '0;
            shift_d = '0;
            rd_d    = '0;
            wr_d    = '0;
            fill_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run_en) begin
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    if (!run_en) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (accept) begin
                        shift_d = word;
                        cnt_d   = done ? '0 : cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (push) begin
                mem_d[wr_q] = word;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            if (push && !pop) begin
                fill_d = fill_q + 1'b1;
            end else if (pop && !push) begin
                fill_d = fill_q - 1'b1;
            end
            if (done && !push) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            fill_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            fill_q  <= fill_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: data is gated by valid below.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out.valid  = (fill_q != '0);
    assign out.data   = out.valid ? mem_q[rd_q] : '0;
    assign fill_level = fill_q;
    assign overflow   = ovf_q;
endmodule

// File: doc/rng_word_packer.md
Name: rng_word_packer

Overview:
- Output-side consumer of the TRNG core. It sits downstream of the generator that the control FSM sequences through LOAD, INIT and RUN.
- While run_en is high, it collects qualified single random bits and packs them into WORD_W-bit words.
- Completed words are buffered in a small FIFO and presented to the system through a valid/ready handshake.
- Overflow is reported, never back-pressured: the generator cannot be stalled.

Parameters:
- WORD_W, 32: bits per output word; legal range 2..64.
- DEPTH, 4: FIFO depth in words; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; highest priority after rst.
- run_en  input  1  from control FSM; high only in RUN.
- bit_valid  input  1  generator bit strobe, e.g. the nlfsr3_ce-qualified output.
- bit_in  input  1  random bit; sampled only when run_en && bit_valid.
- out_data  output  WORD_W  head-of-FIFO word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- fill_level  output  $clog2(DEPTH+1)  words currently held, 0..DEPTH.
- overflow  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (rst=0, async): the following clear immediately.
  - bit counter = 0, shift register = 0
  - FIFO pointers = 0, fill_level = 0
  - out_valid = 0, out_data = 0, overflow = 0
  - state = IDLE
- States: IDLE and COLLECT.
  - IDLE → COLLECT when run_en=1.
  - COLLECT → IDLE when run_en=0. The partial word is discarded and the bit counter returns to 0.
  - FIFO contents are retained across the IDLE transition.
- Bit accept:
  - A bit is accepted when state=COLLECT, run_en=1 and bit_valid=1.
  - In the cycle run_en first rises (state still IDLE), no bit is accepted.
- Packing is LSB-first: the k-th accepted bit of a word (k = 0..WORD_W-1) lands in bit k.
  - Unwritten bits of a word in progress are don't-care but never output.
- Word complete: the accept with counter = WORD_W-1.
  - At that same edge the assembled word (including this bit) is pushed to the FIFO.
  - The counter wraps to 0.
  - Latency: out_valid may rise on the edge of the last bit's accept; data is visible in the following cycle.
- Pop: occurs when out_valid && out_ready. The head advances at that edge. out_data is valid combinationally from the head entry whenever out_valid=1.
- Full with push:
  - With no simultaneous pop, the word is dropped, overflow is set (sticky) and FIFO contents are unchanged.
  - With a simultaneous pop, the push succeeds, fill_level stays at DEPTH and there is no overflow.
- Empty: out_valid=0. out_ready is ignored and no pointer moves.
- Simultaneous push and pop when not full: fill_level is unchanged. Ordering is strictly FIFO.
- Pointer wrap: modulo DEPTH. fill_level is tracked explicitly; full and empty must never be confused.
- clear=1 (sync): takes effect at the next edge.
  - Same state as reset except state follows run_en: COLLECT if run_en=1 at that edge, else IDLE.
  - Any bit or pop presented in that cycle is ignored.
- overflow clears only on rst or clear.
- Reset asserted mid-word or mid-burst: everything is lost immediately. No output glitch beyond going to reset values.

Test Plan:
- Bench uses WORD_W=8, DEPTH=2.
- Basic pack: run_en=1, then 8 strobes with bits 1,0,1,1,0,0,0,1 and out_ready=0.
  - out_valid=1 the cycle after the 8th accept, out_data=8'h8D, fill_level=1.
  - Pulse out_ready for one cycle → out_valid=0, fill_level=0.
- Strobe spacing: bit_valid every 5th cycle, 16 bits 0xA5 then 0x3C LSB-first, out_ready=1.
  - Two words 8'hA5 then 8'h3C, each popped the cycle after completion. overflow=0.
- Overflow: out_ready=0, push 3 words 11h, 22h, 33h.
  - fill_level=2 and overflow=1 after the third word.
  - Drain yields 11h then 22h only.
  - Then clear=1 → overflow=0, fill_level=0.
- Full plus pop: FIFO full (11h, 22h). Complete word 44h in the same cycle as out_ready=1.
  - No overflow, fill_level=2, drain order 22h, 44h.
- Abort: accept 5 bits, drop run_en for 1 cycle, re-raise, then accept 8 bits of 0xF0.
  - The only word output is 8'hF0; the partial bits never appear.
- Async reset: assert rst=0 mid-word with 1 word buffered.
  - out_valid, fill_level and overflow go to 0 before the next clk edge.
  - After release, the next 8 bits form a fresh word.
